// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered immediate generator with two-entry skid buffer
`timescale 1ns/1ps

module imm_decode_stage #(
  parameter int XLEN     = 32,
  parameter bit AUTO_SEL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [2:0]      in_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_sel,
  output logic            out_illegal
);

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_I    = 3'b001;
  localparam logic [2:0] SEL_Z    = 3'b010;
  localparam logic [2:0] SEL_S    = 3'b011;
  localparam logic [2:0] SEL_B    = 3'b100;
  localparam logic [2:0] SEL_U    = 3'b101;
  localparam logic [2:0] SEL_J    = 3'b110;
  localparam logic [2:0] SEL_SH   = 3'b111;

  logic [2:0]      w_funct3;
  logic [2:0]      w_auto_sel;
  logic            w_auto_ill;
  logic            w_auto_sh5;
  logic [2:0]      w_sel;
  logic            w_ill;
  logic            w_sh5;
  logic [XLEN-1:0] w_imm;

  assign w_funct3 = in_inst[14:12];

  // Format derivation from the opcode; w_auto_sh5 picks the 5-bit shamt field.
  always_comb begin
    w_auto_sel = SEL_NONE;
    w_auto_ill = 1'b0;
    w_auto_sh5 = (XLEN == 32);
    if (in_inst[1:0] != 2'b11) begin
      w_auto_ill = 1'b1;
    end else begin
      case (in_inst[6:0])
        7'b0010011: w_auto_sel = (w_funct3[1:0] == 2'b01) ? SEL_SH : SEL_I;
        7'b0000011,
        7'b1100111: w_auto_sel = SEL_I;
        7'b0100011: w_auto_sel = SEL_S;
        7'b1100011: w_auto_sel = SEL_B;
        7'b0110111,
        7'b0010111: w_auto_sel = SEL_U;
        7'b1101111: w_auto_sel = SEL_J;
        7'b1110011: begin
          if (w_funct3[2]) begin
            w_auto_sel = SEL_Z;
          end else if (w_funct3[1:0] != 2'b00) begin
            w_auto_sel = SEL_I;
          end else begin
            w_auto_sel = SEL_NONE;
          end
        end
        7'b0110011,
        7'b0001111: w_auto_sel = SEL_NONE;
        7'b0011011: begin
          if (XLEN == 64) begin
            w_auto_sel = (w_funct3[1:0] == 2'b01) ? SEL_SH : SEL_I;
            w_auto_sh5 = 1'b1;
          end else begin
            w_auto_ill = 1'b1;
          end
        end
        7'b0111011: begin
          if (XLEN != 64) begin
            w_auto_ill = 1'b1;
          end
        end
        default: w_auto_ill = 1'b1;
      endcase
    end
  end

  assign w_sel = AUTO_SEL ? w_auto_sel : in_sel;
  assign w_ill = AUTO_SEL ? w_auto_ill : 1'b0;
  assign w_sh5 = AUTO_SEL ? w_auto_sh5 : (XLEN == 32);

  always_comb begin
    w_imm = '0;
    case (w_sel)
      SEL_I:  w_imm = XLEN'($signed(in_inst[31:20]));
      SEL_Z:  w_imm = XLEN'(in_inst[19:15]);
      SEL_S:  w_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      SEL_B:  w_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                     in_inst[11:8], 1'b0}));
      SEL_U:  w_imm = XLEN'($signed({in_inst[31:12], 12'h000}));
      SEL_J:  w_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                     in_inst[30:21], 1'b0}));
      SEL_SH: w_imm = w_sh5 ? XLEN'(in_inst[24:20]) : XLEN'(in_inst[25:20]);
      default: w_imm = '0;
    endcase
  end

  logic            r_out_valid;
  logic [31:0]     r_out_inst;
  logic [XLEN-1:0] r_out_pc;
  logic [XLEN-1:0] r_out_imm;
  logic [2:0]      r_out_sel;
  logic            r_out_ill;
  logic            r_skid_valid;
  logic [31:0]     r_skid_inst;
  logic [XLEN-1:0] r_skid_pc;
  logic [XLEN-1:0] r_skid_imm;
  logic [2:0]      r_skid_sel;
  logic            r_skid_ill;
  logic            r_in_ready;

  logic w_accept;
  logic w_out_free;
  logic w_out_from_skid;
  logic w_out_from_in;
  logic w_skid_load;
  logic w_out_valid_nxt;
  logic w_skid_valid_nxt;

  // in_ready is its own register so out_ready never reaches it combinationally.
  always_comb begin
    w_accept         = in_valid & r_in_ready & ~flush;
    w_out_free       = ~r_out_valid | out_ready;
    w_out_from_skid  = ~flush & w_out_free & r_skid_valid;
    w_out_from_in    = ~flush & w_out_free & ~r_skid_valid & w_accept;
    w_skid_load      = ~flush & ~w_out_free & w_accept;
    w_out_valid_nxt  = 1'b0;
    w_skid_valid_nxt = 1'b0;
    if (!flush) begin
      if (w_out_free) begin
        w_out_valid_nxt  = r_skid_valid | w_accept;
        w_skid_valid_nxt = 1'b0;
      end else begin
        w_out_valid_nxt  = 1'b1;
        w_skid_valid_nxt = r_skid_valid | w_accept;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_out_valid  <= w_out_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_inst <= '0;
      r_out_pc   <= '0;
      r_out_imm  <= '0;
      r_out_sel  <= '0;
      r_out_ill  <= 1'b0;
    end else if (w_out_from_skid) begin
      r_out_inst <= r_skid_inst;
      r_out_pc   <= r_skid_pc;
      r_out_imm  <= r_skid_imm;
      r_out_sel  <= r_skid_sel;
      r_out_ill  <= r_skid_ill;
    end else if (w_out_from_in) begin
      r_out_inst <= in_inst;
      r_out_pc   <= in_pc;
      r_out_imm  <= w_imm;
      r_out_sel  <= w_sel;
      r_out_ill  <= w_ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_inst <= '0;
      r_skid_pc   <= '0;
      r_skid_imm  <= '0;
      r_skid_sel  <= '0;
      r_skid_ill  <= 1'b0;
    end else if (w_skid_load) begin
      r_skid_inst <= in_inst;
      r_skid_pc   <= in_pc;
      r_skid_imm  <= w_imm;
      r_skid_sel  <= w_sel;
      r_skid_ill  <= w_ill;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_inst    = r_out_inst;
  assign out_pc      = r_out_pc;
  assign out_imm     = r_out_imm;
  assign out_sel     = r_out_sel;
  assign out_illegal = r_out_ill;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - scoreboard bench for imm_decode_stage (XLEN32 auto, XLEN64 auto, XLEN32 manual)
`timescale 1ns/1ps

module tb_imm_decode_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic [2:0]  in_sel;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_inst, a_out_pc, a_out_imm;
  logic [2:0]  a_out_sel;
  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [31:0] b_out_inst;
  logic [63:0] b_out_pc, b_out_imm;
  logic [2:0]  b_out_sel;
  logic        c_in_ready, c_out_valid, c_out_illegal;
  logic [31:0] c_out_inst, c_out_pc, c_out_imm;
  logic [2:0]  c_out_sel;

  imm_decode_stage #(.XLEN(32), .AUTO_SEL(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .in_sel(in_sel), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_inst(a_out_inst), .out_pc(a_out_pc), .out_imm(a_out_imm),
    .out_sel(a_out_sel), .out_illegal(a_out_illegal));

  imm_decode_stage #(.XLEN(64), .AUTO_SEL(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_sel(in_sel), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_inst(b_out_inst), .out_pc(b_out_pc), .out_imm(b_out_imm),
    .out_sel(b_out_sel), .out_illegal(b_out_illegal));

  imm_decode_stage #(.XLEN(32), .AUTO_SEL(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .in_sel(in_sel), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_inst(c_out_inst), .out_pc(c_out_pc), .out_imm(c_out_imm),
    .out_sel(c_out_sel), .out_illegal(c_out_illegal));

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  sel_in;
    logic [31:0] imm_a;
    logic [2:0]  sel_a;
    logic        ill_a;
    logic [63:0] imm_b;
    logic [2:0]  sel_b;
    logic        ill_b;
    logic [31:0] imm_c;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  sel;
    logic        ill;
  } exp_t;

  vec_t vecs[$];
  exp_t qa[$], qb[$], qc[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] inst, input logic [2:0] s_in,
                     input logic [31:0] ia, input logic [2:0] sa, input logic la,
                     input logic [63:0] ib, input logic [2:0] sb, input logic lb,
                     input logic [31:0] ic);
    vec_t v;
    v.inst = inst; v.sel_in = s_in;
    v.imm_a = ia; v.sel_a = sa; v.ill_a = la;
    v.imm_b = ib; v.sel_b = sb; v.ill_b = lb;
    v.imm_c = ic;
    vecs.push_back(v);
  endtask

  function automatic logic [63:0] pc_of(input int s);
    return {32'hC0DE_0000 + 32'(s), 32'h0000_1000 + 32'(4 * s)};
  endfunction

  task automatic present(input int k, input int s);
    in_valid = 1'b1;
    in_inst  = vecs[k].inst;
    in_sel   = vecs[k].sel_in;
    in_pc    = pc_of(s);
  endtask

  task automatic push_exp(input int k, input int s);
    exp_t e;
    logic [63:0] pc;
    pc = pc_of(s);
    e.inst = vecs[k].inst;
    e.pc = {32'h0, pc[31:0]}; e.imm = {32'h0, vecs[k].imm_a};
    e.sel = vecs[k].sel_a; e.ill = vecs[k].ill_a;
    qa.push_back(e);
    e.pc = pc; e.imm = vecs[k].imm_b; e.sel = vecs[k].sel_b; e.ill = vecs[k].ill_b;
    qb.push_back(e);
    e.pc = {32'h0, pc[31:0]}; e.imm = {32'h0, vecs[k].imm_c};
    e.sel = vecs[k].sel_in; e.ill = 1'b0;
    qc.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int k, input int s);
    int n = 0;
    present(k, s);
    while (!a_in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for vector %0d", k);
    end
    @(posedge clk);
    push_exp(k, s);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || qc.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_qa_empty", 64'(qa.size()), 64'd0);
    chk("drain_qb_empty", 64'(qb.size()), 64'd0);
    chk("drain_qc_empty", 64'(qc.size()), 64'd0);
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [31:0] inst,
                     input logic [63:0] pc, input logic [63:0] imm,
                     input logic [2:0] sel, input logic ill);
    chk({tag, "_inst"}, 64'(inst), 64'(e.inst));
    chk({tag, "_pc"}, pc, e.pc);
    chk({tag, "_imm"}, imm, e.imm);
    chk({tag, "_sel_ill"}, 64'({sel, ill}), 64'({e.sel, e.ill}));
  endtask

  task automatic unexpected(input string tag, input logic [31:0] inst);
    total++; bad++;
    $display("FAIL unexpected_out_%s: got inst %h expected no output", tag, inst);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_ready) begin
        if (a_out_valid) begin
          if (qa.size() == 0) unexpected("a", a_out_inst);
          else begin
            e = qa.pop_front();
            cmp("out_a", e, a_out_inst, 64'(a_out_pc), 64'(a_out_imm), a_out_sel, a_out_illegal);
          end
        end
        if (b_out_valid) begin
          if (qb.size() == 0) unexpected("b", b_out_inst);
          else begin
            e = qb.pop_front();
            cmp("out_b", e, b_out_inst, b_out_pc, b_out_imm, b_out_sel, b_out_illegal);
          end
        end
        if (c_out_valid) begin
          if (qc.size() == 0) unexpected("c", c_out_inst);
          else begin
            e = qc.pop_front();
            cmp("out_c", e, c_out_inst, 64'(c_out_pc), 64'(c_out_imm), c_out_sel, c_out_illegal);
          end
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       or_t[7];
    logic       rdy_t[7];
    logic       rdy;
    int         idx, acc;
    time        t0;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0; in_sel = '0;

    //   inst          sel_in  imm_a         sel_a  ill  imm_b                  sel_b  ill  imm_c
    add(32'hFFF00093, 3'b001, 32'hFFFFFFFF, 3'b001, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'b001, 1'b0, 32'hFFFFFFFF);
    add(32'hFE000EE3, 3'b000, 32'hFFFFFFFC, 3'b100, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'b100, 1'b0, 32'h00000000);
    add(32'h3002D073, 3'b010, 32'h00000005, 3'b010, 1'b0, 64'h0000000000000005, 3'b010, 1'b0, 32'h00000005);
    add(32'h03F09093, 3'b111, 32'h0000001F, 3'b111, 1'b0, 64'h000000000000003F, 3'b111, 1'b0, 32'h0000001F);
    add(32'h00000000, 3'b011, 32'h00000000, 3'b000, 1'b1, 64'h0000000000000000, 3'b000, 1'b1, 32'h00000000);
    add(32'h12345037, 3'b101, 32'h12345000, 3'b101, 1'b0, 64'h0000000012345000, 3'b101, 1'b0, 32'h12345000);
    add(32'h8000006F, 3'b110, 32'hFFF00000, 3'b110, 1'b0, 64'hFFFFFFFFFFF00000, 3'b110, 1'b0, 32'hFFF00000);
    add(32'hFE000E23, 3'b100, 32'hFFFFFFFC, 3'b011, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'b011, 1'b0, 32'hFFFFF7FC);
    add(32'h03F0909B, 3'b001, 32'h00000000, 3'b000, 1'b1, 64'h000000000000001F, 3'b111, 1'b0, 32'h0000003F);
    add(32'h0000003B, 3'b000, 32'h00000000, 3'b000, 1'b1, 64'h0000000000000000, 3'b000, 1'b0, 32'h00000000);
    add(32'hC0002073, 3'b001, 32'hFFFFFC00, 3'b001, 1'b0, 64'hFFFFFFFFFFFFFC00, 3'b001, 1'b0, 32'hFFFFFC00);
    add(32'hFFF00091, 3'b101, 32'h00000000, 3'b000, 1'b1, 64'h0000000000000000, 3'b000, 1'b1, 32'hFFF00000);
    add(32'h00000073, 3'b000, 32'h00000000, 3'b000, 1'b0, 64'h0000000000000000, 3'b000, 1'b0, 32'h00000000);
    add(32'h40305093, 3'b111, 32'h00000003, 3'b111, 1'b0, 64'h0000000000000003, 3'b111, 1'b0, 32'h00000003);
    add(32'h80002013, 3'b001, 32'hFFFFF800, 3'b001, 1'b0, 64'hFFFFFFFFFFFFF800, 3'b001, 1'b0, 32'hFFFFF800);
    add(32'h7FF00003, 3'b100, 32'h000007FF, 3'b001, 1'b0, 64'h00000000000007FF, 3'b001, 1'b0, 32'h000007E0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_a_out_inst", 64'(a_out_inst), 64'd0);
    chk("rst_a_out_pc", 64'(a_out_pc), 64'd0);
    chk("rst_a_out_imm", 64'(a_out_imm), 64'd0);
    chk("rst_a_sel_ill", 64'({a_out_sel, a_out_illegal}), 64'd0);
    chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    chk("rst_b_out_imm", b_out_imm, 64'd0);
    chk("rst_c_out_valid", 64'(c_out_valid), 64'd0);
    chk("rst_c_in_ready", 64'(c_in_ready), 64'd1);
    rst_n = 1'b1;
    fork
      monitor();
    join_none
    @(posedge clk); #1;
    chk("post_rst_out_valid", 64'(a_out_valid), 64'd0);

    // Directed vectors, back-to-back with out_ready held high.
    out_ready = 1'b1;
    send(0, 0);
    chk("latency_a_out_valid", 64'(a_out_valid), 64'd1);
    t0 = $time;
    for (int k = 1; k < vecs.size(); k++) send(k, k);
    chk("throughput_cycles", 64'(($time - t0) / 10), 64'(vecs.size() - 1));
    wait_drain();

    // Back-pressure: out_ready low for 3 cycles while 4 instructions are offered.
    or_t  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rdy_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    idx = 0; acc = 0;
    for (int c = 0; c < 7; c++) begin
      out_ready = or_t[c];
      if (idx < 4) present(idx, 100 + idx);
      else in_valid = 1'b0;
      chk($sformatf("bp_in_ready_c%0d", c), 64'(a_in_ready), 64'(rdy_t[c]));
      if (c == 3) begin
        chk("bp_accepts_while_stalled", 64'(acc), 64'd2);
        chk("bp_hold_out_inst", 64'(a_out_inst), 64'(vecs[0].inst));
      end
      rdy = a_in_ready;
      @(posedge clk);
      if (in_valid && rdy) begin
        push_exp(idx, 100 + idx);
        idx++; acc++;
      end
      #1;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", 64'(idx), 64'd4);
    wait_drain();

    // Flush with both entries full and an input offered.
    out_ready = 1'b0;
    send(4, 200);
    send(5, 201);
    present(6, 202);
    flush = 1'b1;
    chk("flush1_pre_in_ready", 64'(a_in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_a_out_valid", 64'(a_out_valid), 64'd0);
    chk("flush1_a_in_ready", 64'(a_in_ready), 64'd1);
    chk("flush1_b_out_valid", 64'(b_out_valid), 64'd0);
    chk("flush1_c_out_valid", 64'(c_out_valid), 64'd0);
    qa.delete(); qb.delete(); qc.delete();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Flush while in_ready=1: the offered input must be dropped.
    out_ready = 1'b0;
    send(7, 210);
    present(8, 211);
    flush = 1'b1;
    chk("flush2_pre_in_ready", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_a_out_valid", 64'(a_out_valid), 64'd0);
    chk("flush2_a_in_ready", 64'(a_in_ready), 64'd1);
    qa.delete(); qb.delete(); qc.delete();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(9, 212);
    wait_drain();

    // Asynchronous reset between edges with both entries full.
    out_ready = 1'b0;
    send(0, 300);
    send(1, 301);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_a_out_valid", 64'(a_out_valid), 64'd0);
    chk("arst_a_in_ready", 64'(a_in_ready), 64'd1);
    chk("arst_a_out_inst", 64'(a_out_inst), 64'd0);
    chk("arst_a_out_imm", 64'(a_out_imm), 64'd0);
    chk("arst_a_out_pc", 64'(a_out_pc), 64'd0);
    chk("arst_a_sel_ill", 64'({a_out_sel, a_out_illegal}), 64'd0);
    chk("arst_b_out_imm", b_out_imm, 64'd0);
    chk("arst_c_out_valid", 64'(c_out_valid), 64'd0);
    qa.delete(); qb.delete(); qc.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_release_out_valid", 64'(a_out_valid), 64'd0);
    out_ready = 1'b1;
    for (int k = 10; k < 16; k++) send(k, 400 + k);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
